// File: rtl/fp32_fma_issue_unit_if.sv
// Handshake, FMA-side and result-side signals of the FMA issue unit, bundled
// so the op producer / result consumer and the unit share one connection.
interface fp32_fma_issue_unit_if #(
  parameter int TAG_WIDTH = 6
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_op;
  logic [TAG_WIDTH-1:0] in_tag;
  logic [31:0]          in_rs1;
  logic [31:0]          in_rs2;
  logic [31:0]          in_rs3;
  logic [31:0]          fma_mullhs;
  logic [31:0]          fma_mulrhs;
  logic [31:0]          fma_addend;
  logic [31:0]          fma_result;
  logic                 out_valid;
  logic                 out_ready;
  logic [TAG_WIDTH-1:0] out_tag;
  logic [31:0]          out_data;

  // Environment side: issues ops, models the FMA, consumes results.
  modport master (
    output flush, in_valid, in_op, in_tag, in_rs1, in_rs2, in_rs3,
    output fma_result, out_ready,
    input  in_ready, fma_mullhs, fma_mulrhs, fma_addend,
    input  out_valid, out_tag, out_data
  );

  // Issue unit side.
  modport slave (
    input  flush, in_valid, in_op, in_tag, in_rs1, in_rs2, in_rs3,
    input  fma_result, out_ready,
    output in_ready, fma_mullhs, fma_mulrhs, fma_addend,
    output out_valid, out_tag, out_data
  );
endinterface

// File: rtl/fp32_fma_issue_unit.sv
// FMA issue wrapper: maps FMA-family ops onto a*b+c, tracks valid/tag beside
// the fixed-latency FMA pipeline and buffers results in a credit-protected FIFO
// so downstream backpressure can never drop a result.
module fp32_fma_issue_unit #(
  parameter int TAG_WIDTH    = 6,
  parameter int FMA_LATENCY  = 4,
  parameter int RESULT_DEPTH = 6
) (
  input logic                   clk,
  input logic                   rst,
  fp32_fma_issue_unit_if.slave  bus
);
  localparam int UW = $clog2(RESULT_DEPTH + 1);
  localparam int PW = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
  localparam logic [31:0] F_SIGN = 32'h8000_0000;
  localparam logic [31:0] F_ONE  = 32'h3f80_0000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } ops_t;

  // Sign flips and constant injection turn every op into a*b+c.
  // FMUL adds -0 so an exact zero product keeps its own sign.
  function automatic ops_t map_ops(input logic [2:0] op, input logic [31:0] rs1,
                                   input logic [31:0] rs2, input logic [31:0] rs3);
    ops_t m;
    m.a = rs1;
    m.b = rs2;
    m.c = rs3;
    case (op)
      3'd1: m.c = rs3 ^ F_SIGN;
      3'd2: m.a = rs1 ^ F_SIGN;
      3'd3: begin m.a = rs1 ^ F_SIGN; m.c = rs3 ^ F_SIGN; end
      3'd4: begin m.b = F_ONE; m.c = rs2; end
      3'd5: begin m.b = F_ONE; m.c = rs2 ^ F_SIGN; end
      3'd6: m.c = F_SIGN;
      default: ;
    endcase
    return m;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(RESULT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic                 w_kill;
  logic                 w_accept;
  logic                 w_pop;
  logic                 w_wr;
  ops_t                 w_ops;

  logic                 r_vld_p0;
  logic [TAG_WIDTH-1:0] r_tag_p0;
  ops_t                 r_ops_p0;

  logic                 r_vld_pipe [FMA_LATENCY];
  logic [TAG_WIDTH-1:0] r_tag_pipe [FMA_LATENCY];

  logic [31:0]          r_fifo_data [RESULT_DEPTH];
  logic [TAG_WIDTH-1:0] r_fifo_tag  [RESULT_DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [UW-1:0]        r_count;
  logic [UW-1:0]        r_used;

  assign w_kill        = rst | bus.flush;
  assign bus.in_ready  = !w_kill && (r_used < UW'(RESULT_DEPTH));
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (r_count != '0);
  assign w_pop         = bus.out_valid && bus.out_ready;
  assign w_wr          = r_vld_pipe[FMA_LATENCY-1];
  assign w_ops         = map_ops(bus.in_op, bus.in_rs1, bus.in_rs2, bus.in_rs3);

  assign bus.fma_mullhs = r_vld_p0 ? r_ops_p0.a : '0;
  assign bus.fma_mulrhs = r_vld_p0 ? r_ops_p0.b : '0;
  assign bus.fma_addend = r_vld_p0 ? r_ops_p0.c : '0;

  assign bus.out_data = bus.out_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign bus.out_tag  = bus.out_valid ? r_fifo_tag[r_rd_ptr]  : '0;

  // p0: issue register valid; holds an op for exactly one cycle.
  always_ff @(posedge clk) begin
    if (w_kill) r_vld_p0 <= 1'b0;
    else        r_vld_p0 <= w_accept;
  end

  // p0: issue register payload, captured on accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tag_p0 <= bus.in_tag;
      r_ops_p0 <= w_ops;
    end
  end

  // p1..pN: valid shift chain aligned with the FMA's internal stages.
  always_ff @(posedge clk) begin
    if (w_kill) begin
      for (int i = 0; i < FMA_LATENCY; i++) r_vld_pipe[i] <= 1'b0;
    end else begin
      r_vld_pipe[0] <= r_vld_p0;
      for (int i = 1; i < FMA_LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
    end
  end

  // p1..pN: tag shift chain travelling beside the valid chain.
  always_ff @(posedge clk) begin
    r_tag_pipe[0] <= r_tag_p0;
    for (int i = 1; i < FMA_LATENCY; i++) r_tag_pipe[i] <= r_tag_pipe[i-1];
  end

  // Result FIFO storage, written when the last stage meets fma_result.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_fifo_data[r_wr_ptr] <= bus.fma_result;
      r_fifo_tag[r_wr_ptr]  <= r_tag_pipe[FMA_LATENCY-1];
    end
  end

  // FIFO pointers and occupancy; a kill discards same-cycle writes and pops.
  always_ff @(posedge clk) begin
    if (w_kill) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      r_count <= r_count + UW'(w_wr) - UW'(w_pop);
    end
  end

  // Credits: every accepted op holds one slot until its result is popped.
  always_ff @(posedge clk) begin
    if (w_kill)                    r_used <= '0;
    else if (w_accept && !w_pop)   r_used <= r_used + 1'b1;
    else if (!w_accept && w_pop)   r_used <= r_used - 1'b1;
  end

  a_no_full_write: assert property (@(posedge clk) disable iff (w_kill)
    !(w_wr && (r_count == UW'(RESULT_DEPTH))));

endmodule

// File: tb/tb_fp32_fma_issue_unit.sv
// Bench for fp32_fma_issue_unit: supplies a 4-cycle FMA model, drives directed
// and random ops, and checks outputs every cycle against an op-level model.
module tb_fp32_fma_issue_unit;
  localparam int TW    = 6;
  localparam int LAT   = 4;
  localparam int DEPTH = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp32_fma_issue_unit_if #(.TAG_WIDTH(TW)) bus();

  fp32_fma_issue_unit #(.TAG_WIDTH(TW), .FMA_LATENCY(LAT), .RESULT_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // binary32 <-> real for normal numbers and signed zeros (all the bench uses)
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:0] == 31'd0) begin
      d = {f[31], 63'd0};
    end else begin
      e = {3'b000, f[30:23]} + 11'd896;
      d = {f[31], e, f[22:0], 29'd0};
    end
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // What each op means arithmetically.
  function automatic logic [31:0] op_ref(input logic [2:0] op, input logic [31:0] x,
                                         input logic [31:0] y, input logic [31:0] z);
    real a, b, c, r;
    a = f2r(x); b = f2r(y); c = f2r(z);
    case (op)
      3'd1:    r = a * b - c;
      3'd2:    r = -(a * b) + c;
      3'd3:    r = -(a * b) - c;
      3'd4:    r = a + b;
      3'd5:    r = a - b;
      3'd6:    r = a * b;
      default: r = a * b + c;
    endcase
    return r2f(r);
  endfunction

  // FMA model: combinational inputs, result registered LAT edges later.
  logic [31:0] fpipe [LAT];
  always @(posedge clk) begin
    fpipe[0] <= r2f(f2r(bus.fma_mullhs) * f2r(bus.fma_mulrhs) + f2r(bus.fma_addend));
    for (int i = 1; i < LAT; i++) fpipe[i] <= fpipe[i-1];
  end
  assign bus.fma_result = fpipe[LAT-1];

  // Scoreboard: outstanding ops in order, each visible from accept cycle + LAT + 2.
  typedef struct {
    logic [TW-1:0] tag;
    logic [31:0]   data;
    int            rdy;
  } ent_t;
  ent_t q[$];
  int   cyc      = 0;
  bit   chk_en   = 1'b0;
  bit   prev_acc = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin : mon
      bit            eir, eov, acc;
      logic [31:0]   ed;
      logic [TW-1:0] et;
      ent_t          e;
      eir = !rst && !bus.flush && (q.size() < DEPTH);
      eov = (q.size() > 0) && (q[0].rdy <= cyc);
      ed  = eov ? q[0].data : 32'd0;
      et  = eov ? q[0].tag : '0;
      chk("in_ready",  32'(bus.in_ready),  32'(eir));
      chk("out_valid", 32'(bus.out_valid), 32'(eov));
      chk("out_data",  bus.out_data, ed);
      chk("out_tag",   32'(bus.out_tag), 32'(et));
      if (!prev_acc) begin
        chk("fma_idle_a", bus.fma_mullhs, 32'd0);
        chk("fma_idle_b", bus.fma_mulrhs, 32'd0);
        chk("fma_idle_c", bus.fma_addend, 32'd0);
      end
      acc = bus.in_valid && eir;
      if (rst || bus.flush) begin
        q.delete();
      end else begin
        if (eov && bus.out_ready) void'(q.pop_front());
        if (acc) begin
          e.tag  = bus.in_tag;
          e.data = op_ref(bus.in_op, bus.in_rs1, bus.in_rs2, bus.in_rs3);
          e.rdy  = cyc + LAT + 2;
          q.push_back(e);
        end
      end
      prev_acc = acc;
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [TW-1:0] tag);
    bus.in_op  = op;
    bus.in_rs1 = a;
    bus.in_rs2 = b;
    bus.in_rs3 = c;
    bus.in_tag = tag;
  endtask

  function automatic logic [31:0] rnd_val();
    int v;
    if ($urandom_range(15) == 0) return 32'h8000_0000;
    v = int'($urandom_range(16)) - 8;
    return r2f(real'(v));
  endfunction

  task automatic set_rand_op(input logic [TW-1:0] tag);
    set_op(3'($urandom_range(7)), rnd_val(), rnd_val(), rnd_val(), tag);
  endtask

  // One isolated op; its result must be absent in cycle 5 and present in cycle 6.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [TW-1:0] tag,
                       input logic [31:0] exp, input string name);
    bus.in_valid = 1'b1;
    set_op(op, a, b, c, tag);
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk({name, "_early"}, 32'(bus.out_valid), 32'd0);
    tick();
    @(negedge clk);
    chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, "_data"}, bus.out_data, exp);
    chk({name, "_tag"}, 32'(bus.out_tag), 32'(tag));
    tick();
  endtask

  initial begin
    int nacc;
    rst = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_op(3'd0, 32'd0, 32'd0, 32'd0, '0);

    @(posedge clk);
    #2;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  bus.out_data, 32'd0);
    chk("rst_fma_a",     bus.fma_mullhs, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();

    do_op(3'd0, 32'h4000_0000, 32'h4040_0000, 32'h3f80_0000, 6'd5,  32'h40e0_0000, "fmadd");
    do_op(3'd1, 32'h4000_0000, 32'h4040_0000, 32'h3f80_0000, 6'd6,  32'h40a0_0000, "fmsub");
    do_op(3'd2, 32'h4000_0000, 32'h4040_0000, 32'h3f80_0000, 6'd7,  32'hc0a0_0000, "fnmsub");
    do_op(3'd3, 32'h4000_0000, 32'h4040_0000, 32'h3f80_0000, 6'd8,  32'hc0e0_0000, "fnmadd");
    do_op(3'd4, 32'h4000_0000, 32'h4040_0000, 32'h3f80_0000, 6'd9,  32'h40a0_0000, "fadd");
    do_op(3'd5, 32'h4000_0000, 32'h4040_0000, 32'h3f80_0000, 6'd10, 32'hbf80_0000, "fsub");
    do_op(3'd6, 32'h4000_0000, 32'h4040_0000, 32'h3f80_0000, 6'd11, 32'h40c0_0000, "fmul");
    do_op(3'd7, 32'h4000_0000, 32'h4040_0000, 32'h3f80_0000, 6'd12, 32'h40e0_0000, "op7");
    do_op(3'd6, 32'h8000_0000, 32'h3f80_0000, 32'h0000_0000, 6'd13, 32'h8000_0000, "fmul_negzero");
    do_op(3'd4, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 6'd14, 32'h0000_0000, "fadd_poszero");

    // Backpressure: 12 cycles of requests with the consumer stalled.
    bus.out_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 1'b1;
      set_rand_op(TW'(20 + i));
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) nacc++;
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepts", 32'(nacc), 32'd6);
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    tick();
    bus.out_ready = 1'b1;
    repeat (14) tick();
    @(negedge clk);
    chk("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
    chk("bp_drained", 32'(bus.out_valid), 32'd0);
    tick();

    // Flush with two results buffered and three still in the FMA.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      set_rand_op(TW'(40 + i));
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    tick();
    bus.flush = 1'b1;
    @(negedge clk);
    chk("fl_buffered", 32'(bus.out_valid), 32'd1);
    tick();
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_in_ready", 32'(bus.in_ready), 32'd1);
    chk("fl_used", 32'(dut.r_used), 32'd0);
    tick();
    do_op(3'd0, 32'h4000_0000, 32'h4040_0000, 32'h3f80_0000, 6'd9, 32'h40e0_0000, "post_flush");

    // Random traffic with sporadic flushes and one mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(9) < 7);
      set_rand_op(TW'($urandom_range(63)));
      bus.out_ready = ($urandom_range(9) < 6);
      bus.flush     = ($urandom_range(49) == 0);
      rst           = (i == 200);
      if (i == 201) begin
        @(negedge clk);
        chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid_out_data", bus.out_data, 32'd0);
        chk("rst_mid_fma_c", bus.fma_addend, 32'd0);
      end
      tick();
    end
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (12) tick();
    @(negedge clk);
    chk("final_empty", 32'(bus.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
